// File: rtl/sqr_int_if.sv
// Handshake and operand bus for the sequential integer squarer.
// Optional self-check signals exist only when SQR_INT_CHECK_EN is defined.
interface sqr_int_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             busy;
   logic             valid;
   logic [WIDTH-1:0] root;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] rad;
   logic             ovf;
`ifdef SQR_INT_CHECK_EN
   logic [WIDTH-1:0] exp_rad;
   logic             chk_ok;

   modport master (output start, root, rem, exp_rad,
                   input  busy, valid, rad, ovf, chk_ok);
   modport slave  (input  start, root, rem, exp_rad,
                   output busy, valid, rad, ovf, chk_ok);
`else
   modport master (output start, root, rem,
                   input  busy, valid, rad, ovf);
   modport slave  (input  start, root, rem,
                   output busy, valid, rad, ovf);
`endif
endinterface

// File: rtl/sqr_int.sv
// Sequential squarer: rad = root*root + rem via shift-add, one root bit per clock.
// Define SQR_INT_CHECK_EN to add the exp_rad / chk_ok reconstruction check.
module sqr_int #(
   parameter int WIDTH = 8
) (
   input  logic     clk,
   input  logic     rst_n,
   sqr_int_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam int AW = 2 * WIDTH;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [AW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rad_q, rad_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;
   logic [AW-1:0]    acc_sum;
   logic             last;

   assign last    = (state_q == RUN) && (cnt_q == LAST);
   assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state: start wins in every state, so it also aborts a running job
   always_comb begin
      state_d = state_q;
      if (bus.start)  state_d = RUN;
      else if (last)  state_d = IDLE;
   end

   // FSM outputs
   always_comb begin
      bus.busy  = (state_q == RUN);
      bus.valid = valid_q;
      bus.rad   = rad_q;
      bus.ovf   = ovf_q;
   end

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      rad_d    = rad_q;
      ovf_d    = ovf_q;
      valid_d  = valid_q;
      if (bus.start) begin
         acc_d    = AW'(bus.rem);
         mcand_d  = AW'(bus.root);
         mplier_d = bus.root;
         cnt_d    = '0;
         valid_d  = 1'b0;
      end else if (state_q == RUN) begin
         acc_d    = acc_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         if (last) begin
            valid_d = 1'b1;
            rad_d   = acc_sum[WIDTH-1:0];
            ovf_d   = |acc_sum[AW-1:WIDTH];
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         rad_q    <= '0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         rad_q    <= rad_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
      end
   end

`ifdef SQR_INT_CHECK_EN
   logic [WIDTH-1:0] exp_q, exp_d;
   logic             rem_ok_q, rem_ok_d;
   logic             chk_q, chk_d;

   // rem <= 2*root is the floor-sqrt condition; evaluated once on the start edge
   always_comb begin
      exp_d    = exp_q;
      rem_ok_d = rem_ok_q;
      chk_d    = chk_q;
      if (bus.start) begin
         exp_d    = bus.exp_rad;
         rem_ok_d = ({1'b0, bus.rem} <= {bus.root, 1'b0});
         chk_d    = 1'b0;
      end else if (last) begin
         chk_d = ~(|acc_sum[AW-1:WIDTH]) && (acc_sum[WIDTH-1:0] == exp_q) && rem_ok_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q    <= '0;
         rem_ok_q <= 1'b0;
         chk_q    <= 1'b0;
      end else begin
         exp_q    <= exp_d;
         rem_ok_q <= rem_ok_d;
         chk_q    <= chk_d;
      end
   end

   assign bus.chk_ok = chk_q;
`endif
endmodule

// File: tb/tb_sqr_int.sv
// Scoreboard bench for sqr_int: driver pushes expected results, monitor pops on valid.
module tb_sqr_int;
   localparam int W = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   typedef struct {
      logic [W-1:0] rad;
      logic         ovf;
      logic         chk;
      int unsigned  se;
   } exp_t;
   exp_t sb[$];

   sqr_int_if #(.WIDTH(W)) bus ();
   sqr_int #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic set_random_inputs();
      bus.root = W'($urandom);
      bus.rem  = W'($urandom);
`ifdef SQR_INT_CHECK_EN
      bus.exp_rad = W'($urandom);
`endif
   endtask

   // Reference: plain arithmetic on the full product
   task automatic issue(input int r, input int m, input int e);
      exp_t        x;
      longint      full;
      int unsigned se;
      @(negedge clk);
      se = cyc + 1;
      if (sb.size() > 0 && (se - sb[$].se) <= W) void'(sb.pop_back());
      full  = longint'(r) * longint'(r) + longint'(m);
      x.rad = W'(full % (64'd1 << W));
      x.ovf = (full >= (64'd1 << W));
      x.chk = !x.ovf && (int'(x.rad) == e) && (m <= 2 * r);
      x.se  = se;
      sb.push_back(x);
      bus.start = 1'b1;
      bus.root  = W'(r);
      bus.rem   = W'(m);
`ifdef SQR_INT_CHECK_EN
      bus.exp_rad = W'(e);
`endif
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.start = 1'b0;
         set_random_inputs();
      end
   endtask

   // Monitor
   initial begin
      logic         vprev;
      logic         exp_busy;
      logic [W-1:0] hold_rad;
      logic         hold_ovf;
      exp_t         e;
      vprev    = 1'b0;
      hold_rad = '0;
      hold_ovf = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            vprev = 1'b0;
         end else begin
            exp_busy = (sb.size() > 0) && (cyc >= sb[0].se) && (cyc < sb[0].se + W);
            check("busy", longint'(bus.busy), longint'(exp_busy));
            if (bus.valid && !vprev) begin
               if (sb.size() == 0) begin
                  check("unexpected_valid", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("rad", longint'(bus.rad), longint'(e.rad));
                  check("ovf", longint'(bus.ovf), longint'(e.ovf));
                  check("latency", longint'(cyc - e.se), longint'(W));
`ifdef SQR_INT_CHECK_EN
                  check("chk_ok", longint'(bus.chk_ok), longint'(e.chk));
`endif
                  hold_rad = e.rad;
                  hold_ovf = e.ovf;
               end
            end else if (bus.valid) begin
               check("hold_rad", longint'(bus.rad), longint'(hold_rad));
               check("hold_ovf", longint'(bus.ovf), longint'(hold_ovf));
            end
            vprev = bus.valid;
         end
      end
   end

   // Driver
   initial begin
      int gap;
      int r;
      bus.start = 1'b0;
      set_random_inputs();
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", longint'(bus.busy), 0);
      check("rst_valid", longint'(bus.valid), 0);
      check("rst_rad", longint'(bus.rad), 0);
      check("rst_ovf", longint'(bus.ovf), 0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(11, 4, 125);  idle(12);
      idle(20);
      issue(15, 30, 255); idle(10);
      issue(16, 0, 0);    idle(10);
      issue(0, 0, 0);     idle(10);

      // Restart three edges into an operation
      issue(9, 0, 81);    idle(2);
      issue(5, 1, 26);    idle(12);

      // start held high keeps restarting
      for (int k = 0; k < 5; k++) issue(k + 3, k, 0);
      idle(12);

      // Asynchronous reset mid-operation
      issue(12, 3, 147);  idle(4);
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("midrst_busy", longint'(bus.busy), 0);
      check("midrst_valid", longint'(bus.valid), 0);
      check("midrst_rad", longint'(bus.rad), 0);
      idle(2);
      rst_n = 1'b1;
      issue(3, 2, 11);    idle(12);

      for (int k = 0; k < 150; k++) begin
         issue(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
               int'($urandom_range(0, (1 << W) - 1)));
         gap = int'($urandom_range(0, 12));
         idle(gap);
      end
      idle(12);

`ifdef SQR_INT_CHECK_EN
      for (int n = 0; n < (1 << W); n++) begin
         r = 0;
         while ((r + 1) * (r + 1) <= n) r++;
         issue(r, n - r * r, n);
         idle(W + 1);
      end
      issue(11, 23, 144); idle(W + 2);
`else
      r = 0;
`endif

      for (int k = 0; k < 50 && sb.size() > 0; k++) @(posedge clk);
      check("scoreboard_drained", longint'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sqr_int.md
Name: sqr_int

Overview:
- Sequential integer squarer; the inverse of the team's integer square-root unit.
- Takes a (root, rem) pair and rebuilds the radicand as rad = root*root + rem, using a shift-add multiplier (one root bit per clock).
- Uses the same start/busy/valid handshake as the square-root unit.
- Sits beside the square-root unit as a self-check and reconstruction engine; also usable standalone for small squaring jobs.

Parameters:
- WIDTH, 8, width of the radicand, root and rem buses; must be even and ≥ 4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new operation; sampled on the rising edge of clk.
- busy  output  1  calculation in progress.
- valid  output  1  rad and ovf are valid.
- root  input  WIDTH  root operand; captured on the start edge.
- rem  input  WIDTH  remainder operand; captured on the start edge.
- rad  output  WIDTH  reconstructed radicand, low WIDTH bits of root*root + rem.
- ovf  output  1  result does not fit in WIDTH bits.

Behaviour:
- Reset (rst_n low, asynchronous):
  - busy = 0, valid = 0, rad = 0, ovf = 0.
  - Internal counter, accumulator and operand copies clear to 0.
  - Takes effect immediately, including mid-operation.
  - First start is accepted on the first rising edge with rst_n high.
- Internal state:
  - acc, 2*WIDTH bits. Maximum value (2^W-1)^2 + (2^W-1) < 2^(2W), so acc never wraps.
  - mcand, 2*WIDTH bits, holds the shifted root.
  - mplier, WIDTH bits.
  - Iteration counter i, $clog2(WIDTH) bits.
- States: IDLE (busy=0), RUN (busy=1). No other states.
- Start edge (start=1, in any state, including RUN):
  - acc <= zero-extended rem; mcand <= zero-extended root; mplier <= root; i <= 0.
  - busy <= 1; valid <= 0.
  - start during RUN aborts the current operation and restarts with the new operands. No result is posted for the aborted operation.
- RUN, each edge with start=0:
  - If mplier[0]=1: acc <= acc + mcand.
  - mcand <= mcand << 1; mplier <= mplier >> 1.
  - On the edge where i == WIDTH-1, apply the final add and then:
    - busy <= 0, valid <= 1.
    - rad <= final acc[WIDTH-1:0].
    - ovf <= OR of final acc[2W-1:WIDTH].
  - Otherwise i <= i+1.
- Latency: start at edge 0 → valid and rad stable after edge WIDTH (8 cycles for the default). busy is high for exactly WIDTH cycles.
- valid, rad and ovf hold until the next start or reset. root and rem changes while busy are ignored.
- start held high continuously keeps restarting: busy stays 1 and valid stays 0.
- IDLE with start=0: all state holds.
- Zero operands need no special casing: root=0 gives rad=rem.

Optional Feature:
- Macro SQR_INT_CHECK_EN.
- When defined, adds:
  - input exp_rad [WIDTH] (captured on the start edge).
  - output chk_ok [1], reset 0.
- chk_ok is registered alongside valid and is set to 1 when all of the following hold:
  - ovf = 0;
  - rad == exp_rad;
  - captured rem ≤ 2*captured root (the condition for root being the floor square root).
- Otherwise chk_ok = 0. chk_ok clears on start and on reset.
- When not defined, neither port exists and the logic is absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, root=11, rem=4, one-cycle start → busy high 8 cycles; valid rises after edge 8; rad=125, ovf=0.
- root=15, rem=30 → rad=255, ovf=0. Then root=16, rem=0 → rad=0, ovf=1. Then root=0, rem=0 → rad=0, ovf=0.
- Restart: start root=9, rem=0; after 3 cycles start root=5, rem=1 → valid exactly 8 cycles after the second start; rad=26; no valid pulse for the first operation.
- Reset: start root=12, rem=3; deassert rst_n after 4 cycles → busy=0, valid=0, rad=0 immediately. Release and start root=3, rem=2 → rad=11 after 8 cycles.
- Hold: after a result of 125, change root/rem with start=0 for 20 cycles → rad=125 and valid=1 unchanged.
- With SQR_INT_CHECK_EN, exhaustive over rad 0..255:
  - Feed the square-root unit's root/rem outputs with exp_rad=rad → chk_ok=1 for every value.
  - root=11, rem=23, exp_rad=144 → rad=144, chk_ok=0 (rem > 22).
